// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank.
// Holds the mode encoding and the single-bit JK next-state function.
package jk_pkg;

    localparam logic MODE_JK  = 1'b0;
    localparam logic MODE_CNT = 1'b1;

    // Classic JK characteristic equation expressed as a truth table.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            2'b00:   nxt = q;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            2'b11:   nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK storage bit with parallel load, enable, counter-mode toggle input
// and a one-cycle change flag.
module jk_cell
    import jk_pkg::*;
#(
    parameter bit   NEG_EDGE = 1'b1,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic mode,
    input  logic load,
    input  logic d,
    input  logic j,
    input  logic k,
    input  logic t,
    output logic q,
    output logic chg
);

    logic q_r;
    logic chg_r;
    logic j_eff_s;
    logic k_eff_s;
    logic q_next_s;
    logic chg_next_s;

    // Select the J/K drive and resolve load > enable > hold.
    always_comb begin
        j_eff_s    = j;
        k_eff_s    = k;
        q_next_s   = q_r;
        chg_next_s = 1'b0;
        if (mode == MODE_CNT) begin
            j_eff_s = t;
            k_eff_s = t;
        end else begin
            j_eff_s = j;
            k_eff_s = k;
        end
        if (load) begin
            q_next_s = d;
        end else if (en) begin
            q_next_s = jk_next(q_r, j_eff_s, k_eff_s);
        end else begin
            q_next_s = q_r;
        end
        chg_next_s = q_r ^ q_next_s;
    end

    // The active clock edge is fixed at elaboration time.
    generate
        if (NEG_EDGE) begin : g_neg
            // State and change flag, falling-edge variant.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_r   <= RST_VAL;
                    chg_r <= 1'b0;
                end else begin
                    q_r   <= q_next_s;
                    chg_r <= chg_next_s;
                end
            end
        end else begin : g_pos
            // State and change flag, rising-edge variant.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_r   <= RST_VAL;
                    chg_r <= 1'b0;
                end else begin
                    q_r   <= q_next_s;
                    chg_r <= chg_next_s;
                end
            end
        end
    endgenerate

    assign q   = q_r;
    assign chg = chg_r;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK cells usable as independent flip-flops or, in counter
// mode, as a synchronous up-counter built from a toggle-enable chain.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int                 WIDTH    = 4,
    parameter bit                 NEG_EDGE = 1'b1,
    parameter logic [WIDTH-1:0]   RST_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] chg,
    output logic             tc
);

    logic [WIDTH-1:0] t_s;
    logic             tc_r;
    logic             tc_next_s;

    // Bit i toggles when every lower bit is one; bit 0 always toggles.
    assign t_s[0] = 1'b1;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_tchain
            assign t_s[gi] = t_s[gi-1] & q[gi-1];
        end

        for (genvar gc = 0; gc < WIDTH; gc++) begin : g_cell
            jk_cell #(
                .NEG_EDGE (NEG_EDGE),
                .RST_VAL  (RST_VAL[gc])
            ) u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .mode  (mode),
                .load  (load),
                .d     (d[gc]),
                .j     (j[gc]),
                .k     (k[gc]),
                .t     (t_s[gc]),
                .q     (q[gc]),
                .chg   (chg[gc])
            );
        end
    endgenerate

    // Wrap is detected from the pre-edge value being all ones.
    always_comb begin
        tc_next_s = 1'b0;
        if (load) begin
            tc_next_s = 1'b0;
        end else if (en && (mode == MODE_CNT)) begin
            tc_next_s = &q;
        end else begin
            tc_next_s = 1'b0;
        end
    end

    generate
        if (NEG_EDGE) begin : g_tc_neg
            // Terminal-count pulse register, falling-edge variant.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tc_r <= 1'b0;
                end else begin
                    tc_r <= tc_next_s;
                end
            end
        end else begin : g_tc_pos
            // Terminal-count pulse register, rising-edge variant.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tc_r <= 1'b0;
                end else begin
                    tc_r <= tc_next_s;
                end
            end
        end
    endgenerate

    assign tc   = tc_r;
    assign qbar = ~q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: a falling-edge instance and a
// rising-edge instance share stimulus; one is monitored per phase.
module tb_jk_reg_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       load;
    logic [3:0] d;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q_a, qbar_a, chg_a;
    logic [3:0] q_b, qbar_b, chg_b;
    logic       tc_a, tc_b;

    logic [3:0] q_m, qbar_m, chg_m;
    logic       tc_m;
    logic       sel;
    logic [3:0] last_q;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [3:0] q;
        logic [3:0] qbar;
        logic [3:0] chg;
        logic       tc;
        string      name;
    } exp_t;

    exp_t sb[$];

    jk_reg_bank #(.WIDTH(4), .NEG_EDGE(1'b1), .RST_VAL(4'b0000)) u_neg (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .d(d), .j(j), .k(k), .q(q_a), .qbar(qbar_a), .chg(chg_a), .tc(tc_a)
    );

    jk_reg_bank #(.WIDTH(4), .NEG_EDGE(1'b0), .RST_VAL(4'b0000)) u_pos (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .d(d), .j(j), .k(k), .q(q_b), .qbar(qbar_b), .chg(chg_b), .tc(tc_b)
    );

    assign q_m    = sel ? q_b    : q_a;
    assign qbar_m = sel ? qbar_b : qbar_a;
    assign chg_m  = sel ? chg_b  : chg_a;
    assign tc_m   = sel ? tc_b   : tc_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_outs(input string nm, input logic [3:0] eq, input logic [3:0] eqb,
                              input logic [3:0] ech, input logic etc);
        n_tests++;
        if ({q_m, qbar_m, chg_m, tc_m} !== {eq, eqb, ech, etc}) begin
            n_fail++;
            $display("FAIL %s: got q=%b qbar=%b chg=%b tc=%b, expected q=%b qbar=%b chg=%b tc=%b",
                     nm, q_m, qbar_m, chg_m, tc_m, eq, eqb, ech, etc);
        end
    endtask

    // Monitor: after each active edge of the selected instance, pop and compare.
    always begin
        if (sel) @(posedge clk);
        else     @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_outs(e.name, e.q, e.qbar, e.chg, e.tc);
        end
    end

    task automatic step(input logic l, input logic e, input logic m,
                        input logic [3:0] dd, input logic [3:0] jj, input logic [3:0] kk,
                        input logic [3:0] eq, input logic [3:0] ech, input logic etc,
                        input string nm);
        exp_t x;
        if (sel) @(negedge clk);
        else     @(posedge clk);
        #1;
        n_tests++;
        if (q_m !== last_q) begin
            n_fail++;
            $display("FAIL inactive_edge(%s): got q=%b, expected q=%b", nm, q_m, last_q);
        end
        load = l; en = e; mode = m; d = dd; j = jj; k = kk;
        x.q = eq; x.qbar = ~eq; x.chg = ech; x.tc = etc; x.name = nm;
        sb.push_back(x);
        last_q = eq;
    endtask

    task automatic counter_run(input string nm);
        logic [3:0] o;
        logic [3:0] n;
        for (int i = 0; i < 16; i++) begin
            o = 4'(i);
            n = o + 4'd1;
            step(1'b0, 1'b1, 1'b1, 4'h0, 4'b1010, 4'b0101, n, o ^ n, (i == 15), nm);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sel     = 1'b0;
        last_q  = 4'h0;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0;
        d = 4'h0; j = 4'h0; k = 4'h0;
        #2;
        check_outs("reset_initial", 4'h0, 4'hF, 4'h0, 1'b0);
        #1 rst_n = 1'b1;

        // Load 1011, then assert reset mid-cycle with no clock edge.
        step(1'b1, 1'b0, 1'b0, 4'b1011, 4'h0, 4'h0, 4'b1011, 4'b1011, 1'b0, "load_1011");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check_outs("async_reset", 4'h0, 4'hF, 4'h0, 1'b0);
        @(negedge clk); #1;
        check_outs("reset_held_over_edge", 4'h0, 4'hF, 4'h0, 1'b0);
        #1 rst_n = 1'b1;
        last_q = 4'h0;

        // JK mode: toggle, reset, set, hold on bits 0..3.
        step(1'b1, 1'b0, 1'b0, 4'b1100, 4'h0, 4'h0, 4'b1100, 4'b1100, 1'b0, "load_1100");
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'b0101, 4'b0011, 4'b1101, 4'b0001, 1'b0, "jk_mixed");
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'b1111, 4'b1111, 4'b0010, 4'b1111, 1'b0, "jk_toggle_all");
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'b1100, 4'b0010, 4'b1100, 4'b1110, 1'b0, "jk_set_reset");
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'b1111, 4'b0000, 4'b0000, 4'b1100, 1'b0, "load_over_en");

        counter_run("cnt_neg");

        step(1'b1, 1'b0, 1'b1, 4'hA, 4'h0, 4'h0, 4'hA, 4'b1010, 1'b0, "load_A");
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'hB, 4'b0001, 1'b0, "cnt_after_load");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 4'hB, 4'h0, 1'b0, "en0_hold");
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hB, 4'h0, 1'b0, "mode_switch_hold");

        // Load 1111 then count: wraps with tc, then load drops tc.
        step(1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 4'b0100, 1'b0, "load_F");
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, "wrap_tc");
        step(1'b1, 1'b1, 1'b1, 4'h3, 4'h0, 4'h0, 4'h3, 4'h3, 1'b0, "load_clears_tc");

        // Rising-edge instance: same counter sequence after a fresh reset.
        repeat (3) @(posedge clk);
        #2;
        sel = 1'b1;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; mode = 1'b0;
        #1 check_outs("reset_pos", 4'h0, 4'hF, 4'h0, 1'b0);
        #1 rst_n = 1'b1;
        last_q = 4'h0;
        counter_run("cnt_pos");

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
